// File: rtl/serial_digit_addsub_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
// Holds the add/sub mode encoding and the word-width helper.
package serial_addsub_pkg;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } addsub_mode_t;

    function automatic int word_w(input int digit_w, input int word_digits);
        return digit_w * word_digits;
    endfunction

endpackage

// File: rtl/serial_digit_addsub_fa.sv
// Combinational DIGIT_W-bit ripple full adder built only from logic operators.
// Exposes the carry into the MSB so the caller can derive signed overflow.
module digit_full_adder #(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               cin,
    output logic [DIGIT_W-1:0] sum,
    output logic               cout,
    output logic               c_msb_in
);

    // Ripple chain: each stage forms s=a^b^c and co=(a&b)|(c&(a^b)).
    always_comb begin
        logic [DIGIT_W:0] carry_v;
        carry_v    = {(DIGIT_W+1){1'b0}};
        carry_v[0] = cin;
        sum        = {DIGIT_W{1'b0}};
        for (int i = 0; i < DIGIT_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry_v[i];
            carry_v[i+1] = (a[i] & b[i]) | (carry_v[i] & (a[i] ^ b[i]));
        end
        cout     = carry_v[DIGIT_W];
        c_msb_in = carry_v[DIGIT_W-1];
    end

endmodule

// File: rtl/serial_digit_addsub.sv
// Digit-serial LSB-first adder/subtractor: DIGIT_W bits per beat, WORD_DIGITS beats per word,
// one-cycle registered result with end-of-word carry-out and signed overflow.
module serial_digit_addsub
    import serial_addsub_pkg::*;
#(
    parameter int DIGIT_W     = 1,
    parameter int WORD_DIGITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [DIGIT_W-1:0] in_a,
    input  logic [DIGIT_W-1:0] in_b,
    input  logic               in_sub,
    output logic               out_valid,
    output logic [DIGIT_W-1:0] out_sum,
    output logic               out_last,
    output logic               out_carry,
    output logic               out_overflow
);

    localparam int CNT_W = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_DIGITS - 1);

    if (word_w(DIGIT_W, WORD_DIGITS) < 1) begin : g_bad_params
        $error("serial_digit_addsub: DIGIT_W and WORD_DIGITS must both be >= 1");
    end

    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    addsub_mode_t       mode_r;
    logic               out_valid_r;
    logic [DIGIT_W-1:0] out_sum_r;
    logic               out_last_r;
    logic               out_carry_r;
    logic               out_overflow_r;

    logic               first_s;
    logic               last_s;
    addsub_mode_t       mode_s;
    logic               cin_s;
    logic [DIGIT_W-1:0] b_eff_s;
    logic [DIGIT_W-1:0] sum_s;
    logic               cout_s;
    logic               c_msb_in_s;

    assign first_s = (cnt_r == {CNT_W{1'b0}});
    assign last_s  = (cnt_r == LAST_CNT);

    // Beat 0 takes mode and carry-in from the live in_sub; later beats use the held state.
    always_comb begin
        mode_s = MODE_ADD;
        cin_s  = 1'b0;
        if (first_s) begin
            mode_s = addsub_mode_t'(in_sub);
            cin_s  = in_sub;
        end else begin
            mode_s = mode_r;
            cin_s  = carry_r;
        end
    end

    // Subtraction adds the ones' complement of B; the +1 comes from the beat-0 carry-in.
    always_comb begin
        b_eff_s = in_b;
        case (mode_s)
            MODE_SUB: b_eff_s = ~in_b;
            MODE_ADD: b_eff_s = in_b;
            default:  b_eff_s = in_b;
        endcase
    end

    digit_full_adder #(
        .DIGIT_W (DIGIT_W)
    ) u_fa (
        .a        (in_a),
        .b        (b_eff_s),
        .cin      (cin_s),
        .sum      (sum_s),
        .cout     (cout_s),
        .c_msb_in (c_msb_in_s)
    );

    // Word state and output registers; gaps hold everything except out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r          <= {CNT_W{1'b0}};
            carry_r        <= 1'b0;
            mode_r         <= MODE_ADD;
            out_valid_r    <= 1'b0;
            out_sum_r      <= {DIGIT_W{1'b0}};
            out_last_r     <= 1'b0;
            out_carry_r    <= 1'b0;
            out_overflow_r <= 1'b0;
        end else if (in_valid) begin
            cnt_r          <= last_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1'b1));
            carry_r        <= cout_s;
            mode_r         <= mode_s;
            out_valid_r    <= 1'b1;
            out_sum_r      <= sum_s;
            out_last_r     <= last_s;
            out_carry_r    <= last_s & cout_s;
            out_overflow_r <= last_s & (c_msb_in_s ^ cout_s);
        end else begin
            out_valid_r    <= 1'b0;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_sum      = out_sum_r;
    assign out_last     = out_last_r;
    assign out_carry    = out_carry_r;
    assign out_overflow = out_overflow_r;

endmodule

// File: tb/tb_serial_digit_addsub.sv
// Directed and table-driven bench for serial_digit_addsub (4x2 word instance plus a 1x1 instance).
module tb_serial_digit_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 4-bit digit, 2-beat word instance
    logic       w_valid = 1'b0, w_sub = 1'b0;
    logic [3:0] w_a = 4'h0, w_b = 4'h0;
    logic       w_ovalid, w_olast, w_ocarry, w_oovf;
    logic [3:0] w_osum;

    // 1-bit digit, 1-beat word instance
    logic       b_valid = 1'b0, b_sub = 1'b0;
    logic [0:0] b_a = 1'b0, b_b = 1'b0;
    logic       b_ovalid, b_olast, b_ocarry, b_oovf;
    logic [0:0] b_osum;

    serial_digit_addsub #(.DIGIT_W(4), .WORD_DIGITS(2)) dut_w (
        .clk(clk), .rst(rst), .in_valid(w_valid), .in_a(w_a), .in_b(w_b), .in_sub(w_sub),
        .out_valid(w_ovalid), .out_sum(w_osum), .out_last(w_olast),
        .out_carry(w_ocarry), .out_overflow(w_oovf)
    );

    serial_digit_addsub #(.DIGIT_W(1), .WORD_DIGITS(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_a(b_a), .in_b(b_b), .in_sub(b_sub),
        .out_valid(b_ovalid), .out_sum(b_osum), .out_last(b_olast),
        .out_carry(b_ocarry), .out_overflow(b_oovf)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_w(input string nm, input logic [3:0] s, input logic l,
                         input logic c, input logic v);
        chk({nm, ".valid"}, {31'd0, w_ovalid}, 32'd1);
        chk({nm, ".sum"},   {28'd0, w_osum},   {28'd0, s});
        chk({nm, ".last"},  {31'd0, w_olast},  {31'd0, l});
        chk({nm, ".carry"}, {31'd0, w_ocarry}, {31'd0, c});
        chk({nm, ".ovf"},   {31'd0, w_oovf},   {31'd0, v});
    endtask

    typedef struct {
        string      name;
        logic [3:0] a0, b0, a1, b1;
        logic       sub;
        logic [3:0] s0, s1;
        logic       c, v;
    } vec_t;

    vec_t vecs[8];

    logic       exp_s, exp_c, exp_v, beff;

    initial begin
        vecs[0] = '{"add7F+01", 4'hF, 4'h1, 4'h7, 4'h0, 1'b0, 4'h0, 4'h8, 1'b0, 1'b1};
        vecs[1] = '{"sub00-01", 4'h0, 4'h1, 4'h0, 4'h0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0};
        vecs[2] = '{"sub05-03", 4'h5, 4'h3, 4'h0, 4'h0, 1'b1, 4'h2, 4'h0, 1'b1, 1'b0};
        vecs[3] = '{"addFF+01", 4'hF, 4'h1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0};
        vecs[4] = '{"sub80-01", 4'h0, 4'h1, 4'h8, 4'h0, 1'b1, 4'hF, 4'h7, 1'b1, 1'b1};
        vecs[5] = '{"add00+00", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0};
        vecs[6] = '{"add12+34", 4'h2, 4'h4, 4'h1, 4'h3, 1'b0, 4'h6, 4'h4, 1'b0, 1'b0};
        vecs[7] = '{"add40+40", 4'h0, 4'h0, 4'h4, 4'h4, 1'b0, 4'h0, 4'h8, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.valid", {31'd0, w_ovalid}, 32'd0);
        chk("rst.sum",   {28'd0, w_osum},   32'd0);
        chk("rst.last",  {31'd0, w_olast},  32'd0);
        chk("rst.carry", {31'd0, w_ocarry}, 32'd0);
        chk("rst.ovf",   {31'd0, w_oovf},   32'd0);
        chk("rst.b_valid", {31'd0, b_ovalid}, 32'd0);
        rst = 1'b0;

        // Table words back-to-back; in_sub is inverted on beat 1 and must be ignored
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) chk_w({vecs[i-1].name, ".b1"}, vecs[i-1].s1, 1'b1, vecs[i-1].c, vecs[i-1].v);
            w_valid = 1'b1; w_a = vecs[i].a0; w_b = vecs[i].b0; w_sub = vecs[i].sub;
            @(negedge clk);
            chk_w({vecs[i].name, ".b0"}, vecs[i].s0, 1'b0, 1'b0, 1'b0);
            w_a = vecs[i].a1; w_b = vecs[i].b1; w_sub = ~vecs[i].sub;
        end
        @(negedge clk);
        chk_w({vecs[7].name, ".b1"}, vecs[7].s1, 1'b1, vecs[7].c, vecs[7].v);
        w_valid = 1'b0; w_sub = 1'b0;

        // Gapped 0x7F+0x01 with in_sub toggling during the idle cycles
        @(negedge clk);
        w_valid = 1'b1; w_a = 4'hF; w_b = 4'h1; w_sub = 1'b0;
        @(negedge clk);
        chk_w("gap.b0", 4'h0, 1'b0, 1'b0, 1'b0);
        w_valid = 1'b0; w_sub = 1'b1;
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            chk("gap.idle_valid", {31'd0, w_ovalid}, 32'd0);
            chk("gap.idle_sum",   {28'd0, w_osum},   32'd0);
            w_sub = ~w_sub;
        end
        w_valid = 1'b1; w_a = 4'h7; w_b = 4'h0; w_sub = 1'b1;
        @(negedge clk);
        chk_w("gap.b1", 4'h8, 1'b1, 1'b0, 1'b1);
        w_valid = 1'b0; w_sub = 1'b0;

        // Asynchronous reset after beat 0, then a fresh word
        @(negedge clk);
        w_valid = 1'b1; w_a = 4'hF; w_b = 4'hF; w_sub = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", {31'd0, w_ovalid}, 32'd0);
        chk("arst.sum",   {28'd0, w_osum},   32'd0);
        chk("arst.last",  {31'd0, w_olast},  32'd0);
        chk("arst.carry", {31'd0, w_ocarry}, 32'd0);
        chk("arst.ovf",   {31'd0, w_oovf},   32'd0);
        @(negedge clk);
        rst = 1'b0; w_a = 4'h2; w_b = 4'h4; w_sub = 1'b0;
        @(negedge clk);
        chk_w("post_rst.b0", 4'h6, 1'b0, 1'b0, 1'b0);
        w_a = 4'h1; w_b = 4'h3;
        @(negedge clk);
        chk_w("post_rst.b1", 4'h4, 1'b1, 1'b0, 1'b0);
        w_valid = 1'b0;

        // 1x1 instance: random beats against a full-adder reference
        for (int i = 0; i <= 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b.valid", {31'd0, b_ovalid}, 32'd1);
                chk("b.sum",   {31'd0, b_osum},   {31'd0, exp_s});
                chk("b.last",  {31'd0, b_olast},  32'd1);
                chk("b.carry", {31'd0, b_ocarry}, {31'd0, exp_c});
                chk("b.ovf",   {31'd0, b_oovf},   {31'd0, exp_v});
            end
            if (i < 1000) begin
                b_valid = 1'b1;
                b_a     = 1'($urandom_range(1, 0));
                b_b     = 1'($urandom_range(1, 0));
                b_sub   = 1'($urandom_range(1, 0));
                beff    = b_b[0] ^ b_sub;
                exp_s   = b_a[0] ^ beff ^ b_sub;
                exp_c   = (b_a[0] & beff) | (b_sub & (b_a[0] ^ beff));
                exp_v   = b_sub ^ exp_c;
            end else begin
                b_valid = 1'b0;
            end
        end

        @(negedge clk);
        chk("b.idle_valid", {31'd0, b_ovalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
